// File: rtl/reg_wb_arbiter_if.sv
// Bundle of writeback, issue/scoreboard and register-file write signals.
//   a_*     : ALU writeback channel (valid/addr/data in, ready out)
//   m_*     : load-unit writeback channel (valid/addr/data in, ready out)
//   issue_* : decoder issue of an instruction writing issue_rd
//   chk_*   : source-register busy queries
//   flush   : clears the scoreboard
//   we/waddr/wdata : registered register-file write port
// Modport "slave" is the arbiter's view; "master" is the driver's view.
interface reg_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;

    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_busy1;
    logic              chk_busy2;

    logic              flush;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  m_valid, m_addr, m_data,
        output m_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  chk_addr1, chk_addr2,
        output chk_busy1, chk_busy2,
        input  flush,
        output we, waddr, wdata
    );

    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output m_valid, m_addr, m_data,
        input  m_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output chk_addr1, chk_addr2,
        input  chk_busy1, chk_busy2,
        output flush,
        input  we, waddr, wdata
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// Two writeback channels (ALU, load) compete for one register-file write
// port; contention is resolved by a 1-bit round-robin pointer. A per-register
// saturating counter tracks outstanding writes so the decoder can stall on
// hazards (chk_busy*) and on counter overflow (issue_ready).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : reg_wb_arbiter_if.slave (channels, issue, queries, flush, write port)
module reg_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input logic               clk,
    input logic               rst,
    reg_wb_arbiter_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              rr;
    logic [CNT_W-1:0]  cnt [NREG];

    logic              grant_a_p0;
    logic              grant_m_p0;
    logic              acc_p0;
    logic              contended_p0;
    logic [ADDR_W-1:0] acc_addr_p0;
    logic [DATA_W-1:0] acc_data_p0;
    logic              issue_fire_p0;
    logic              wb_same_rd_p0;

    logic              we_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;

    // Stage p0: arbitration, scoreboard queries and issue gating
    always_comb begin
        contended_p0  = bus.a_valid && bus.m_valid && !rst;
        grant_a_p0    = !rst && bus.a_valid && (!bus.m_valid || !rr);
        grant_m_p0    = !rst && bus.m_valid && (!bus.a_valid ||  rr);
        acc_p0        = grant_a_p0 || grant_m_p0;
        acc_addr_p0   = grant_m_p0 ? bus.m_addr : bus.a_addr;
        acc_data_p0   = grant_m_p0 ? bus.m_data : bus.a_data;

        // A same-cycle writeback frees a slot, so a full counter may still issue.
        wb_same_rd_p0 = acc_p0 && (acc_addr_p0 == bus.issue_rd);
        bus.issue_ready = !rst && ((bus.issue_rd == '0) ||
                                   (cnt[bus.issue_rd] != CNT_MAX) ||
                                   wb_same_rd_p0);
        issue_fire_p0 = bus.issue_valid && bus.issue_ready;

        bus.a_ready   = grant_a_p0;
        bus.m_ready   = grant_m_p0;

        bus.chk_busy1 = (bus.chk_addr1 != '0) && (cnt[bus.chk_addr1] != '0);
        bus.chk_busy2 = (bus.chk_addr2 != '0) && (cnt[bus.chk_addr2] != '0);
    end

    // Round-robin pointer moves to the loser only when both channels competed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (contended_p0) begin
            rr <= !rr;
        end
    end

    // Scoreboard counters; register 0 is pinned to zero.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue_fire_p0 && (bus.issue_rd == ADDR_W'(r)) &&
                    !(acc_p0 && (acc_addr_p0 == ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (acc_p0 && (acc_addr_p0 == ADDR_W'(r)) &&
                             !(issue_fire_p0 && (bus.issue_rd == ADDR_W'(r))) &&
                             (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Stage p1: registered register-file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1    <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            // Writes to register 0 are consumed silently; address/data hold.
            we_p1 <= acc_p0 && (acc_addr_p0 != '0);
            if (acc_p0 && (acc_addr_p0 != '0)) begin
                waddr_p1 <= acc_addr_p0;
                wdata_p1 <= acc_data_p0;
            end
        end
    end

    assign bus.we    = we_p1;
    assign bus.waddr = waddr_p1;
    assign bus.wdata = wdata_p1;
endmodule
